fifo_rr_drain: RTL and testbench

Round-robin read-side scheduler that shares one downstream sample stream among NUM_CH asynchronous sample FIFOs. Runs entirely in the FIFO read clock domain. Grants one non-empty, enabled FIFO at a time, pops a fixed-length burst of BURST_LEN words through a registered valid/ready output, and tags each beat with its channel and an end-of-burst flag. Feeds the packetizer/DSP chain downstream of the per-channel asynchronous FIFOs.

---
 rtl/fifo_drain_pkg.sv | 19 +
 rtl/fifo_rr_drain_rr_pick.sv | 35 +++
 rtl/fifo_rr_drain.sv | 164 ++++++++++++++++
 tb/tb_fifo_rr_drain.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and width helpers for the round-robin FIFO drain scheduler.
package fifo_drain_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   // Index width for an n-entry selector; never zero so ports stay legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must be able to hold the value n itself.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// Rotating-priority selector: first eligible channel at or after rr_ptr, cyclic.
module rr_pick
   import fifo_drain_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CW     = idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] eligible,
   input  logic [CW-1:0]     rr_ptr,
   output logic [CW-1:0]     grant,
   output logic              found
);

   localparam logic [CW:0] NCH = (CW+1)'(NUM_CH);

   logic [2*NUM_CH-1:0] dbl;
   logic [NUM_CH-1:0]   rot;
   logic [CW-1:0]       ofs;
   logic [CW:0]         sum;

   always_comb begin
      // Rotate so rr_ptr lands at bit 0, then take the lowest set bit.
      dbl   = {eligible, eligible};
      rot   = NUM_CH'(dbl >> rr_ptr);
      ofs   = '0;
      found = |eligible;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rot[i]) ofs = CW'(i);
      end
      sum = {1'b0, rr_ptr} + {1'b0, ofs};
      if (sum >= NCH) sum = sum - NCH;
      grant = sum[CW-1:0];
   end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin read-side scheduler: drains fixed-length bursts from NUM_CH
// show-ahead FIFOs into one registered valid/ready stream.
module fifo_rr_drain
   import fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int BURST_LEN  = 8,
   parameter int STALL_MAX  = 16
) (
   input  logic                         rclk,
   input  logic                         rrst,
   input  logic [NUM_CH-1:0]            chan_en,
   input  logic [NUM_CH-1:0]            fifo_empty,
   input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rdata,
   output logic [NUM_CH-1:0]            fifo_r_en,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic [$clog2(NUM_CH)-1:0]    m_chan,
   output logic                         m_last,
   output logic [NUM_CH-1:0]            starve,
   input  logic [NUM_CH-1:0]            starve_clr,
   output logic                         busy
);

   localparam int CW = $clog2(NUM_CH);
   localparam int BW = cnt_w(BURST_LEN);
   localparam int SW = cnt_w(STALL_MAX);
   localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_LEN - 1);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
   localparam logic [CW:0]   NCH        = (CW+1)'(NUM_CH);

   state_e                state_q, state_d;
   logic [CW-1:0]         grant_q, grant_d;
   logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
   logic [SW-1:0]         stall_cnt_q, stall_cnt_d;
   logic                  m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [CW-1:0]         m_chan_q, m_chan_d;
   logic                  m_last_q, m_last_d;
   logic [NUM_CH-1:0]     starve_q, starve_d;

   logic [DATA_WIDTH-1:0] head [NUM_CH];
   logic [NUM_CH-1:0]     eligible;
   logic [NUM_CH-1:0]     starve_set;
   logic [CW-1:0]         pick_grant;
   logic                  pick_found;
   logic                  can_load;
   logic [CW:0]           gsum;
   logic [CW-1:0]         rr_next;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_head
      assign head[c] = fifo_rdata[c*DATA_WIDTH +: DATA_WIDTH];
   end

   assign eligible = chan_en & ~fifo_empty;

   rr_pick #(.NUM_CH(NUM_CH), .CW(CW)) u_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .grant    (pick_grant),
      .found    (pick_found)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_chan_d    = m_chan_q;
      m_last_d    = m_last_q;
      starve_set  = '0;
      fifo_r_en   = '0;

      can_load = !m_valid_q || m_ready;
      gsum     = {1'b0, grant_q} + 1'b1;
      rr_next  = (gsum == NCH) ? '0 : gsum[CW-1:0];

      if (can_load) m_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d     = pick_grant;
               beat_cnt_d  = '0;
               stall_cnt_d = '0;
               state_d     = BURST;
            end
         end
         BURST: begin
            if (can_load) begin
               if (!fifo_empty[grant_q]) begin
                  fifo_r_en[grant_q] = 1'b1;
                  m_valid_d   = 1'b1;
                  m_data_d    = head[grant_q];
                  m_chan_d    = grant_q;
                  m_last_d    = (beat_cnt_q == BEAT_LAST);
                  beat_cnt_d  = beat_cnt_q + 1'b1;
                  stall_cnt_d = '0;
                  if (beat_cnt_q == BEAT_LAST) begin
                     rr_ptr_d = rr_next;
                     state_d  = IDLE;
                  end
               end else begin
                  stall_cnt_d = stall_cnt_q + 1'b1;
                  // Close the burst with a zero beat so downstream framing stays intact.
                  if (stall_cnt_q == STALL_LAST) begin
                     m_valid_d           = 1'b1;
                     m_data_d            = '0;
                     m_chan_d            = grant_q;
                     m_last_d            = 1'b1;
                     starve_set[grant_q] = 1'b1;
                     rr_ptr_d            = rr_next;
                     state_d             = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      starve_d = (starve_q & ~starve_clr) | starve_set;
      if (rrst) fifo_r_en = '0;
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_chan_q    <= '0;
         m_last_q    <= 1'b0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_chan_q    <= m_chan_d;
         m_last_q    <= m_last_d;
         starve_q    <= starve_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_chan  = m_chan_q;
   assign m_last  = m_last_q;
   assign starve  = starve_q;
   assign busy    = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Scoreboard bench for fifo_rr_drain: FIFO models feed the DUT, expected beats
// are queued as stimulus is issued and compared on each output handshake.
module tb_fifo_rr_drain;

   localparam int DW  = 16;
   localparam int NCH = 4;
   localparam int BL  = 4;
   localparam int SM  = 8;

   logic              rclk       = 1'b0;
   logic              rrst       = 1'b1;
   logic [NCH-1:0]    chan_en    = '1;
   logic [NCH-1:0]    fifo_empty = '1;
   logic [NCH*DW-1:0] fifo_rdata = '0;
   logic [NCH-1:0]    fifo_r_en;
   logic              m_valid;
   logic              m_ready    = 1'b1;
   logic [DW-1:0]     m_data;
   logic [1:0]        m_chan;
   logic              m_last;
   logic [NCH-1:0]    starve;
   logic [NCH-1:0]    starve_clr = '0;
   logic              busy;

   fifo_rr_drain #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BURST_LEN(BL), .STALL_MAX(SM)) dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .chan_en    (chan_en),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_r_en  (fifo_r_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_chan     (m_chan),
      .m_last     (m_last),
      .starve     (starve),
      .starve_clr (starve_clr),
      .busy       (busy)
   );

   always #5 rclk = ~rclk;

   typedef logic [DW-1:0] wq_t [$];
   wq_t         fq [NCH];
   logic [31:0] exp_q [$];

   int          n_chk = 0, n_err = 0;
   int          hs_cnt = 0, cyc = 0, last_hs = 0, last_gap = 0;
   bit          chk_tput = 1'b0, prev_last = 1'b0, hold_prev = 1'b0;
   logic [19:0] prev_out = '0;
   logic [NCH-1:0] pop_v;
   logic [3:0]  pat = 4'b1001;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] wd(input int tg, input int c, input int i);
      return 16'((tg << 12) | (c << 8) | i);
   endfunction

   task automatic fill(input int tg, input int c, input int n, input int start);
      for (int i = 0; i < n; i++) fq[c].push_back(wd(tg, c, start + i));
   endtask

   task automatic exp_burst(input int tg, input int c, input int start, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({13'b0, (i == BL - 1), 2'(c), wd(tg, c, start + i)});
   endtask

   task automatic tick();
      @(posedge rclk);
      #2;
   endtask

   task automatic wait_hs(input int target, input int budget, input string tag);
      int n = 0;
      while (hs_cnt < target && n < budget) begin
         @(negedge rclk);
         #1;
         n++;
      end
      chk({tag, "_timeout"}, 32'(hs_cnt >= target), 1);
   endtask

   always @(posedge rclk) cyc++;

   // FIFO model: pops on the strobe seen at the edge, then presents the new head.
   always @(posedge rclk) begin
      pop_v = fifo_r_en;
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (pop_v[c] && fq[c].size() > 0) void'(fq[c].pop_front());
         fifo_empty[c] = (fq[c].size() == 0);
         fifo_rdata[c*DW +: DW] = fifo_empty[c] ? 16'h0 : fq[c][0];
      end
   end

   always @(negedge rclk) begin
      chk("ren_empty", {28'b0, fifo_r_en & fifo_empty}, 0);
      chk("ren_onehot", {31'b0, $onehot0(fifo_r_en)}, 1);
      chk("stall_pop", {28'b0, fifo_r_en & {NCH{m_valid & ~m_ready}}}, 0);
      if (hold_prev && !rrst)
         chk("hold", {12'b0, m_valid, m_last, m_chan, m_data}, {12'b0, prev_out});
      if (m_valid && m_ready && !rrst) begin
         if (chk_tput && hs_cnt > 0) chk("gap", cyc - last_hs, prev_last ? 2 : 1);
         last_gap  = cyc - last_hs;
         last_hs   = cyc;
         prev_last = m_last;
         hs_cnt++;
         if (exp_q.size() == 0) chk("extra_beat", {13'b0, m_last, m_chan, m_data}, 32'hFFFF_FFFF);
         else                   chk("beat", {13'b0, m_last, m_chan, m_data}, exp_q.pop_front());
      end
      hold_prev = m_valid && !m_ready && !rrst;
      prev_out  = {m_valid, m_last, m_chan, m_data};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int base;
      int i;

      // Reset held with every FIFO loaded, then fairness across all four channels.
      for (int c = 0; c < NCH; c++) fill(1, c, 8, 0);
      repeat (3) begin
         tick();
         @(negedge rclk);
         #1;
         chk("rst_ren", 32'(fifo_r_en), 0);
         chk("rst_valid", 32'(m_valid), 0);
         chk("rst_starve", 32'(starve), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_out", {13'b0, m_last, m_chan, m_data}, 0);
      end
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NCH; c++) exp_burst(1, c, r * BL, BL);
      base     = hs_cnt;
      chk_tput = 1'b1;
      rrst     = 1'b0;
      wait_hs(base + 32, 200, "fair");
      chk_tput = 1'b0;

      // Backpressure on a ch1 burst.
      tick();
      fill(2, 1, 4, 0);
      exp_burst(2, 1, 0, 4);
      base = hs_cnt;
      i    = 0;
      while (hs_cnt < base + 4 && i < 100) begin
         m_ready = pat[i % 4];
         tick();
         i++;
      end
      m_ready = 1'b1;
      chk("bp_timeout", 32'(hs_cnt >= base + 4), 1);
      chk("bp_left", fq[1].size(), 0);

      // Starvation: ch2 has only two words.
      tick();
      fill(3, 2, 2, 0);
      exp_burst(3, 2, 0, 2);
      exp_q.push_back({13'b0, 1'b1, 2'd2, 16'h0});
      base = hs_cnt;
      wait_hs(base + 3, 100, "starve");
      chk("abort_gap", last_gap, SM);
      chk("starve_set", 32'(starve), 32'h4);
      starve_clr = 4'b0100;
      tick();
      starve_clr = 4'b0000;
      @(negedge rclk);
      #1;
      chk("starve_clr", 32'(starve), 0);

      // Masking: only ch1 and ch3 enabled, all FIFOs loaded.
      tick();
      chan_en = 4'b1010;
      for (int c = 0; c < NCH; c++) fill(4, c, 8, 0);
      exp_burst(4, 3, 0, 4);
      exp_burst(4, 1, 0, 4);
      exp_burst(4, 3, 4, 4);
      exp_burst(4, 1, 4, 4);
      base = hs_cnt;
      wait_hs(base + 16, 200, "mask");
      tick();
      tick();
      chk("mask_ch0_left", fq[0].size(), 8);
      chk("mask_ch2_left", fq[2].size(), 8);
      chan_en = 4'b0000;
      tick();
      fq[0].delete();
      fq[2].delete();
      tick();
      tick();

      // Mid-burst reset during a ch3 burst; ch0 must win first afterwards.
      chan_en = 4'b1111;
      fill(5, 3, 10, 0);
      exp_burst(5, 3, 0, 2);
      base = hs_cnt;
      wait_hs(base + 2, 50, "mid_rst");
      rrst = 1'b1;
      @(negedge rclk);
      #1;
      chk("mr_valid", 32'(m_valid), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_ren", 32'(fifo_r_en), 0);
      chk("mr_sb", exp_q.size(), 0);
      chk("mr_ch3_left", fq[3].size(), 8);
      fill(5, 0, 4, 0);
      tick();
      tick();
      exp_burst(5, 0, 0, 4);
      exp_burst(5, 3, 2, 4);
      exp_burst(5, 3, 6, 4);
      base = hs_cnt;
      rrst = 1'b0;
      wait_hs(base + 12, 200, "post_rst");

      tick();
      tick();
      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
